wb_data_select: RTL and testbench
=================================

Name: wb_data_select

Overview:
- Parametrised, registered successor to the register-file write-data selector in the multicycle MIPS datapath.
- Picks one of N_SRC data sources, or the built-in constant (stack-pointer init 227), on a write-back request.
- Captures the chosen value with its destination register and holds it valid until the register file accepts it.
- Never latches: an illegal select raises an error flag instead of keeping a stale combinational value.

Parameters:
- DATA_W, 32, data width.
- N_SRC, 6, number of external data sources, indices 0..N_SRC-1.
- SEL_W, 3, select width; must satisfy 2^SEL_W >= N_SRC+1.
- CONST_VAL, 227, constant driven when sel == N_SRC.
- DEST_W, 5, destination register index width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- sel  in  SEL_W  source select, sampled with wb_req.
- data_in  in  N_SRC*DATA_W  flattened sources; source i is bits [i*DATA_W +: DATA_W].
- dest_in  in  DEST_W  destination register, sampled with wb_req.
- wb_req  in  1  write-back request, single-cycle or level.
- rf_ready  in  1  register file accepts the held write this cycle.
- wb_data  out  DATA_W  captured write data.
- wb_dest  out  DEST_W  captured destination.
- wb_valid  out  1  wb_data/wb_dest hold a pending write.
- sel_err  out  1  one-cycle pulse: request with illegal sel.
- overrun  out  1  sticky: request dropped while a write was pending.

Behaviour:
- Reset (sync, reset=1 at a rising edge):
  - wb_data=0, wb_dest=0, wb_valid=0, sel_err=0, overrun=0.
  - FSM goes to IDLE; a pending write is discarded.
- Source decode (combinational, internal):
  - sel < N_SRC: selects data_in slice sel.
  - sel == N_SRC: selects CONST_VAL, zero-extended or truncated to DATA_W.
  - sel > N_SRC: illegal.
- FSM states: IDLE, PEND.
- IDLE:
  - wb_req with legal sel: capture decoded data and dest_in; wb_valid=1 next cycle; go to PEND. Latency is 1 cycle from request to valid.
  - wb_req with illegal sel: sel_err=1 for exactly one cycle; wb_data/wb_dest unchanged; stay in IDLE.
  - No request: hold all outputs.
- PEND:
  - rf_ready=1 and wb_req=1 with legal sel: back-to-back. Capture the new value and dest; wb_valid stays 1; stay in PEND.
  - rf_ready=1 and wb_req=1 with illegal sel: sel_err pulses; wb_valid=0; go to IDLE.
  - rf_ready=1, no request: wb_valid=0; go to IDLE; wb_data/wb_dest keep their last value.
  - rf_ready=0 and wb_req=1: request dropped; overrun=1 (sticky until reset); held data unchanged. If sel is also illegal, sel_err pulses as well.
  - rf_ready=0, no request: hold.
- rf_ready while in IDLE is ignored.
- sel_err is registered: it asserts in the cycle after the offending request.
- Outputs are driven only from registers; no combinational path from inputs to outputs.

Decomposition:
- Shared package wb_pkg:
  - FSM state typedef {IDLE, PEND}.
  - default constants SP_INIT=227, DATA_W=32, DEST_W=5.
- Sub-module src_mux_n: parametrised combinational N-to-1 mux plus constant.
  - Outputs: decoded data and sel_legal.
  - Reused by the PC-source and ALU-operand selectors.
- Top module: FSM, capture registers, flags.

Test Plan:
- reset high 2 cycles, then low -> all outputs 0; wb_req with sel=1, data_in[1]=0xDEADBEEF, dest_in=8 -> next cycle wb_valid=1, wb_data=0xDEADBEEF, wb_dest=8.
- wb_req sel=6 (=N_SRC), dest_in=29 -> wb_data=227, wb_dest=29; rf_ready=1 one cycle -> wb_valid=0, wb_data still 227.
- wb_req sel=7 -> sel_err high exactly one cycle, wb_valid=0, wb_data unchanged.
- PEND with rf_ready=1 and wb_req sel=0 (data_in[0]=0x11) in the same cycle -> wb_valid stays 1, wb_data=0x11 next cycle.
- PEND with rf_ready=0 and wb_req sel=2 -> overrun=1, wb_data keeps the old value; overrun stays 1 through later writes until reset.
- reset asserted during PEND -> next cycle wb_valid=0, overrun=0, all outputs 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and default constants for the write-back data selector and its sibling
// operand/PC-source selectors.
package wb_pkg;

  localparam int unsigned SP_INIT    = 227;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEST_W = 5;
  localparam int unsigned DEF_N_SRC  = 6;
  localparam int unsigned DEF_SEL_W  = 3;

  typedef enum logic [0:0] {
    StIdle,
    StPend
  } wb_state_e;

  // The select field must be able to encode every source plus the constant slot.
  function automatic bit sel_width_ok(input int unsigned sel_w, input int unsigned n_src);
    return (64'd1 << sel_w) >= 64'(n_src + 1);
  endfunction

endpackage

// File: rtl/wb_data_select_if.sv
// Bundle of request, source and register-file handshake signals between the datapath
// and the write-back selector.
interface wb_data_select_if
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned N_SRC  = DEF_N_SRC,
  parameter int unsigned SEL_W  = DEF_SEL_W,
  parameter int unsigned DEST_W = DEF_DEST_W
) ();

  logic [SEL_W-1:0]        sel;
  logic [N_SRC*DATA_W-1:0] data_in;
  logic [DEST_W-1:0]       dest_in;
  logic                    wb_req;
  logic                    rf_ready;

  logic [DATA_W-1:0]       wb_data;
  logic [DEST_W-1:0]       wb_dest;
  logic                    wb_valid;
  logic                    sel_err;
  logic                    overrun;

  modport master (
    output sel, data_in, dest_in, wb_req, rf_ready,
    input  wb_data, wb_dest, wb_valid, sel_err, overrun
  );

  modport slave (
    input  sel, data_in, dest_in, wb_req, rf_ready,
    output wb_data, wb_dest, wb_valid, sel_err, overrun
  );

endinterface

// File: rtl/src_mux_n.sv
// Combinational N-to-1 source mux with one extra constant slot at index N_SRC; any
// higher select value is reported as illegal and yields zero.
module src_mux_n #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned N_SRC     = 6,
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned CONST_VAL = 227
) (
  input  logic [SEL_W-1:0]        sel_i,
  input  logic [N_SRC*DATA_W-1:0] data_i,
  output logic [DATA_W-1:0]       data_o,
  output logic                    legal_o
);

  always_comb begin
    data_o  = '0;
    legal_o = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (sel_i == SEL_W'(i)) begin
        data_o  = data_i[i*DATA_W +: DATA_W];
        legal_o = 1'b1;
      end
    end
    if (sel_i == SEL_W'(N_SRC)) begin
      data_o  = DATA_W'(CONST_VAL);
      legal_o = 1'b1;
    end
  end

endmodule

// File: rtl/wb_data_select.sv
// Registered write-back data selector: captures the chosen source and destination on a
// request and holds them valid until the register file accepts the write.
module wb_data_select
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned N_SRC     = DEF_N_SRC,
  parameter int unsigned SEL_W     = DEF_SEL_W,
  parameter int unsigned CONST_VAL = SP_INIT,
  parameter int unsigned DEST_W    = DEF_DEST_W
) (
  input logic              clk,
  input logic              reset,
  wb_data_select_if.slave  bus
);

  if (!sel_width_ok(SEL_W, N_SRC)) begin : g_bad_sel_w
    $error("wb_data_select: SEL_W too narrow for N_SRC sources plus constant");
  end

  wb_state_e         state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic              err_q, err_d;
  logic              ovr_q, ovr_d;

  logic [DATA_W-1:0] mux_data;
  logic              mux_legal;
  logic              req_legal;
  logic              req_illegal;

  src_mux_n #(
    .DATA_W   (DATA_W),
    .N_SRC    (N_SRC),
    .SEL_W    (SEL_W),
    .CONST_VAL(CONST_VAL)
  ) u_src_mux (
    .sel_i  (bus.sel),
    .data_i (bus.data_in),
    .data_o (mux_data),
    .legal_o(mux_legal)
  );

  assign req_legal   = bus.wb_req & mux_legal;
  assign req_illegal = bus.wb_req & ~mux_legal;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (req_legal) state_d = StPend;
      // Accepted write leaves PEND unless a legal request refills it in the same cycle.
      StPend: if (bus.rf_ready && !req_legal) state_d = StIdle;
    endcase
  end

  always_comb begin
    data_d = data_q;
    dest_d = dest_q;
    err_d  = req_illegal;
    ovr_d  = ovr_q;
    unique case (state_q)
      StIdle: begin
        if (req_legal) begin
          data_d = mux_data;
          dest_d = bus.dest_in;
        end
      end
      StPend: begin
        if (bus.rf_ready) begin
          if (req_legal) begin
            data_d = mux_data;
            dest_d = bus.dest_in;
          end
        end else if (bus.wb_req) begin
          ovr_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      dest_q <= '0;
      err_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      dest_q <= dest_d;
      err_q  <= err_d;
      ovr_q  <= ovr_d;
    end
  end

  assign bus.wb_data  = data_q;
  assign bus.wb_dest  = dest_q;
  assign bus.wb_valid = (state_q == StPend);
  assign bus.sel_err  = err_q;
  assign bus.overrun  = ovr_q;

endmodule

// File: tb/tb_wb_data_select.sv
// Randomised scoreboard bench for wb_data_select: a stimulus task pushes the expected
// post-edge outputs, a negedge monitor pops and compares them.
module tb_wb_data_select;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned N_SRC     = 6;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned CONST_VAL = 227;
  localparam int unsigned DEST_W    = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_data_select_if #(
    .DATA_W(DATA_W),
    .N_SRC (N_SRC),
    .SEL_W (SEL_W),
    .DEST_W(DEST_W)
  ) bus ();

  wb_data_select #(
    .DATA_W   (DATA_W),
    .N_SRC    (N_SRC),
    .SEL_W    (SEL_W),
    .CONST_VAL(CONST_VAL),
    .DEST_W   (DEST_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [DEST_W-1:0] dest;
    logic              valid;
    logic              err;
    logic              ovr;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: one pending write slot plus a sticky overrun flag.
  bit                m_pend;
  logic [DATA_W-1:0] m_data;
  logic [DEST_W-1:0] m_dest;
  bit                m_ovr;

  logic [DATA_W-1:0] src [N_SRC];
  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  task automatic step(input bit rst, input bit req, input int unsigned sel,
                      input int unsigned dest, input bit rdy);
    exp_t              e;
    logic [DATA_W-1:0] val;
    bit                legal;
    reset        = rst;
    bus.wb_req   = req;
    bus.sel      = SEL_W'(sel);
    bus.dest_in  = DEST_W'(dest);
    bus.rf_ready = rdy;
    for (int i = 0; i < int'(N_SRC); i++) bus.data_in[i*DATA_W +: DATA_W] = src[i];
    legal = (sel <= N_SRC);
    val   = (sel < N_SRC) ? src[sel] : DATA_W'(CONST_VAL);
    e.err = 1'b0;
    if (rst) begin
      m_pend = 0;
      m_data = '0;
      m_dest = '0;
      m_ovr  = 0;
    end else begin
      e.err = req && !legal;
      if (req && (!m_pend || rdy)) begin
        if (legal) begin
          m_pend = 1;
          m_data = val;
          m_dest = DEST_W'(dest);
        end else begin
          m_pend = 0;
        end
      end else if (req) begin
        m_ovr = 1;
      end else if (rdy) begin
        m_pend = 0;
      end
    end
    e.data  = m_data;
    e.dest  = m_dest;
    e.valid = m_pend;
    e.ovr   = m_ovr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  exp_t got;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        got = exp_q.pop_front();
        chk("wb_data",  bus.wb_data,  got.data);
        chk("wb_dest",  DATA_W'(bus.wb_dest), DATA_W'(got.dest));
        chk("wb_valid", DATA_W'(bus.wb_valid), DATA_W'(got.valid));
        chk("sel_err",  DATA_W'(bus.sel_err),  DATA_W'(got.err));
        chk("overrun",  DATA_W'(bus.overrun),  DATA_W'(got.ovr));
      end
    end
  end

  initial begin
    for (int i = 0; i < int'(N_SRC); i++) src[i] = $urandom();
    src[1] = 32'hDEAD_BEEF;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 8, 0);   // capture DEADBEEF -> r8
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);   // accepted
    step(0, 1, 6, 29, 0);  // constant slot
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);   // rf_ready ignored in idle
    step(0, 1, 7, 3, 0);   // illegal select
    step(0, 0, 0, 0, 0);
    step(0, 1, 3, 4, 0);
    src[0] = 32'h11;
    step(0, 1, 0, 5, 1);   // back-to-back
    step(0, 0, 0, 0, 0);
    step(0, 1, 2, 6, 0);   // dropped -> overrun
    step(0, 1, 7, 6, 0);   // dropped and illegal
    step(0, 0, 0, 0, 1);
    step(0, 1, 4, 7, 0);
    step(0, 1, 7, 7, 1);   // illegal while accepting
    step(0, 1, 5, 9, 0);
    step(1, 0, 0, 0, 0);   // reset while pending
    step(0, 0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) src[$urandom_range(0, N_SRC - 1)] = $urandom();
      step($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
           $urandom_range(0, 31), $urandom_range(0, 1) == 1);
    end
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", DATA_W'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
